// File: rtl/rrt_pkg.sv
// Shared definitions for the reaction-game round sequencer and its scorer:
// round state encoding, winner codes and the saturating delay helper.
package rrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // 17-bit sum clamped to the 16-bit range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/reaction_round_timer_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock, reloads SEED on reset.
module lfsr16
    import rrt_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        cin,
    input  logic        reset_n,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge cin) begin
        if (!reset_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/reaction_round_timer.sv
// Round sequencer: random hold-off, go cue, reaction measurement and a
// one-cycle result strobe for the scorer.
module reaction_round_timer
    import rrt_pkg::*;
#(
    parameter logic [15:0] MIN_MS       = 16'd1000,
    parameter logic [15:0] RANGE_MASK   = 16'h0FFF,
    parameter logic [15:0] MAX_REACT_MS = 16'd2000,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        cin,
    input  logic        reset_n,
    input  logic        tick_ms,
    input  logic        start,
    input  logic        abort,
    input  logic        p1_hit,
    input  logic        p2_hit,
    output logic        in_progress,
    output logic        go,
    output logic        result_valid,
    output logic [1:0]  winner,
    output logic        early,
    output logic [15:0] reaction_ms,
    output logic [15:0] delay_ms
);

    localparam logic [15:0] L_LAST_RCNT = MAX_REACT_MS - 16'd1;

    logic [15:0] w_lfsr;
    logic [15:0] w_delay;
    logic        w_hit;
    logic [1:0]  w_hitter;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_rcnt;
    logic        r_in_progress;
    logic        r_go;
    logic        r_result_valid;
    logic [1:0]  r_winner;
    logic        r_early;
    logic [15:0] r_reaction_ms;
    logic [15:0] r_delay_ms;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .cin     (cin),
        .reset_n (reset_n),
        .o_value (w_lfsr)
    );

    assign w_delay  = sat_add16(MIN_MS, w_lfsr & RANGE_MASK);
    assign w_hit    = p1_hit | p2_hit;
    assign w_hitter = p1_hit ? WIN_P1 : WIN_P2;

    always_ff @(posedge cin) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rcnt         <= '0;
            r_in_progress  <= 1'b0;
            r_go           <= 1'b0;
            r_result_valid <= 1'b0;
            r_winner       <= WIN_NONE;
            r_early        <= 1'b0;
            r_reaction_ms  <= '0;
            r_delay_ms     <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (abort) begin
                r_state       <= IDLE;
                r_in_progress <= 1'b0;
                r_go          <= 1'b0;
            end else if (start && r_state != DONE) begin
                // A start in WAIT or GO silently restarts with a fresh delay.
                r_state       <= WAIT;
                r_delay_ms    <= w_delay;
                r_cnt         <= w_delay;
                r_in_progress <= 1'b1;
                r_go          <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    WAIT: begin
                        if (w_hit) begin
                            r_state       <= DONE;
                            r_winner      <= w_hitter;
                            r_early       <= 1'b1;
                            r_reaction_ms <= '0;
                            r_in_progress <= 1'b0;
                        end else if (tick_ms) begin
                            if (r_cnt == 16'd1) begin
                                r_state <= GO;
                                r_go    <= 1'b1;
                                r_rcnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt - 16'd1;
                            end
                        end
                    end
                    GO: begin
                        if (w_hit) begin
                            r_state       <= DONE;
                            r_winner      <= w_hitter;
                            r_early       <= 1'b0;
                            r_reaction_ms <= r_rcnt;
                            r_in_progress <= 1'b0;
                            r_go          <= 1'b0;
                        end else if (tick_ms) begin
                            if (r_rcnt == L_LAST_RCNT) begin
                                r_state       <= DONE;
                                r_winner      <= WIN_NONE;
                                r_early       <= 1'b0;
                                r_reaction_ms <= MAX_REACT_MS;
                                r_in_progress <= 1'b0;
                                r_go          <= 1'b0;
                            end else begin
                                r_rcnt <= r_rcnt + 16'd1;
                            end
                        end
                    end
                    DONE: begin
                        r_result_valid <= 1'b1;
                        r_state        <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_progress  = r_in_progress;
    assign go           = r_go;
    assign result_valid = r_result_valid;
    assign winner       = r_winner;
    assign early        = r_early;
    assign reaction_ms  = r_reaction_ms;
    assign delay_ms     = r_delay_ms;

endmodule

// File: tb/tb_reaction_round_timer.sv
// Bench for reaction_round_timer: directed vector table, randomized run
// against a round-level model, and a delay-range sweep with default parameters.
module tb_reaction_round_timer;
    import rrt_pkg::*;

    typedef struct packed {
        logic st, ab, h1, h2, tk;
    } in_t;

    typedef struct packed {
        logic        ip;
        logic        go;
        logic        rv;
        logic [1:0]  win;
        logic        early;
        logic [15:0] react;
        logic [15:0] delay;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] S  = 5'b10000;
    localparam logic [4:0] A  = 5'b01000;
    localparam logic [4:0] H1 = 5'b00100;
    localparam logic [4:0] H2 = 5'b00010;
    localparam logic [4:0] T  = 5'b00001;

    logic cin = 1'b0;
    always #10 cin = ~cin;
    logic reset_n;

    in_t a_in, b_in, c_in;
    logic a_ip, a_go, a_rv, a_e, b_ip, b_go, b_rv, b_e, c_ip, c_go, c_rv, c_e;
    logic [1:0] a_w, b_w, c_w;
    logic [15:0] a_r, a_d, b_r, b_d, c_r, c_d;
    out_t a_out, b_out, c_out;
    assign a_out = {a_ip, a_go, a_rv, a_w, a_e, a_r, a_d};
    assign b_out = {b_ip, b_go, b_rv, b_w, b_e, b_r, b_d};
    assign c_out = {c_ip, c_go, c_rv, c_w, c_e, c_r, c_d};

    reaction_round_timer #(.MIN_MS(16'd3), .RANGE_MASK(16'h0000), .MAX_REACT_MS(16'd10), .SEED(16'hACE1)) u_a (
        .cin(cin), .reset_n(reset_n), .tick_ms(a_in.tk), .start(a_in.st), .abort(a_in.ab),
        .p1_hit(a_in.h1), .p2_hit(a_in.h2), .in_progress(a_ip), .go(a_go), .result_valid(a_rv),
        .winner(a_w), .early(a_e), .reaction_ms(a_r), .delay_ms(a_d));

    reaction_round_timer #(.MIN_MS(16'd2), .RANGE_MASK(16'h000F), .MAX_REACT_MS(16'd6), .SEED(16'hACE1)) u_b (
        .cin(cin), .reset_n(reset_n), .tick_ms(b_in.tk), .start(b_in.st), .abort(b_in.ab),
        .p1_hit(b_in.h1), .p2_hit(b_in.h2), .in_progress(b_ip), .go(b_go), .result_valid(b_rv),
        .winner(b_w), .early(b_e), .reaction_ms(b_r), .delay_ms(b_d));

    reaction_round_timer u_c (
        .cin(cin), .reset_n(reset_n), .tick_ms(c_in.tk), .start(c_in.st), .abort(c_in.ab),
        .p1_hit(c_in.h1), .p2_hit(c_in.h2), .in_progress(c_ip), .go(c_go), .result_valid(c_rv),
        .winner(c_w), .early(c_e), .reaction_ms(c_r), .delay_ms(c_d));

    // Reference LFSR straight from the polynomial definition.
    logic [15:0] ref_lfsr;
    always @(posedge cin) begin
        if (!reset_n) ref_lfsr <= 16'hACE1;
        else          ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cin);
        @(negedge cin);
    endtask

    task automatic av(input logic [4:0] i, input logic ip, input logic g, input logic rv,
                      input logic [1:0] w, input logic e, input logic [15:0] r, input logic [15:0] d);
        vec_t v;
        v.i = i;
        v.o = {ip, g, rv, w, e, r, d};
        vq.push_back(v);
    endtask

    // Round-level reference for u_b (MIN 2, mask 0xF, window 6 ms).
    bit m_active, m_gone, m_pending;
    int m_left, m_elapsed;
    out_t exp_b;

    task automatic model_step(input in_t i);
        bit done_now;
        done_now = m_pending;
        m_pending = 0;
        exp_b.rv = 1'b0;
        if (i.ab) begin
            m_active = 0;
            m_gone = 0;
        end else if (done_now) begin
            exp_b.rv = 1'b1;
        end else if (i.st) begin
            exp_b.delay = sat_add16(16'd2, ref_lfsr & 16'h000F);
            m_left = int'(exp_b.delay);
            m_active = 1;
            m_gone = 0;
        end else if (m_active && (i.h1 || i.h2)) begin
            exp_b.win = i.h1 ? 2'd1 : 2'd2;
            exp_b.early = !m_gone;
            exp_b.react = m_gone ? 16'(m_elapsed) : 16'd0;
            m_active = 0;
            m_gone = 0;
            m_pending = 1;
        end else if (m_active && i.tk) begin
            if (!m_gone) begin
                m_left--;
                if (m_left == 0) begin
                    m_gone = 1;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed == 6) begin
                    exp_b.win = 2'd0;
                    exp_b.early = 1'b0;
                    exp_b.react = 16'd6;
                    m_active = 0;
                    m_gone = 0;
                    m_pending = 1;
                end
            end
        end
        exp_b.ip = m_active;
        exp_b.go = m_active && m_gone;
    endtask

    initial begin
        reset_n = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;
        repeat (3) cyc();
        chk("reset_outputs", 64'(a_out), 64'(out_t'('0)));
        reset_n = 1'b1;

        // Directed table for u_a: delay fixed at 3, window 10.
        av(H1, 0,0,0, 2'd0,0, 16'd0, 16'd0);
        av(S,  1,0,0, 2'd0,0, 16'd0, 16'd3);
        av(T,  1,0,0, 2'd0,0, 16'd0, 16'd3);
        av(N,  1,0,0, 2'd0,0, 16'd0, 16'd3);
        av(T,  1,0,0, 2'd0,0, 16'd0, 16'd3);
        av(T,  1,1,0, 2'd0,0, 16'd0, 16'd3);
        for (int k = 0; k < 7; k++) av(T, 1,1,0, 2'd0,0, 16'd0, 16'd3);
        av(H2, 0,0,0, 2'd2,0, 16'd7, 16'd3);
        av(N,  0,0,1, 2'd2,0, 16'd7, 16'd3);
        av(N,  0,0,0, 2'd2,0, 16'd7, 16'd3);
        av(S,  1,0,0, 2'd2,0, 16'd7, 16'd3);
        av(T,  1,0,0, 2'd2,0, 16'd7, 16'd3);
        av(H1, 0,0,0, 2'd1,1, 16'd0, 16'd3);
        av(S,  0,0,1, 2'd1,1, 16'd0, 16'd3);
        av(N,  0,0,0, 2'd1,1, 16'd0, 16'd3);
        av(S,  1,0,0, 2'd1,1, 16'd0, 16'd3);
        av(T,  1,0,0, 2'd1,1, 16'd0, 16'd3);
        av(T,  1,0,0, 2'd1,1, 16'd0, 16'd3);
        av(T,  1,1,0, 2'd1,1, 16'd0, 16'd3);
        for (int k = 0; k < 9; k++) av(T, 1,1,0, 2'd1,1, 16'd0, 16'd3);
        av(T,  0,0,0, 2'd0,0, 16'd10, 16'd3);
        av(N,  0,0,1, 2'd0,0, 16'd10, 16'd3);
        av(S,  1,0,0, 2'd0,0, 16'd10, 16'd3);
        av(T,  1,0,0, 2'd0,0, 16'd10, 16'd3);
        av(T,  1,0,0, 2'd0,0, 16'd10, 16'd3);
        av(T,  1,1,0, 2'd0,0, 16'd10, 16'd3);
        av(T,  1,1,0, 2'd0,0, 16'd10, 16'd3);
        av(T,  1,1,0, 2'd0,0, 16'd10, 16'd3);
        av(H1|H2|T, 0,0,0, 2'd1,0, 16'd2, 16'd3);
        av(N,  0,0,1, 2'd1,0, 16'd2, 16'd3);
        av(S,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(S,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,1,0, 2'd1,0, 16'd2, 16'd3);
        av(S,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  1,0,0, 2'd1,0, 16'd2, 16'd3);
        av(A,  0,0,0, 2'd1,0, 16'd2, 16'd3);
        av(N,  0,0,0, 2'd1,0, 16'd2, 16'd3);
        av(T,  0,0,0, 2'd1,0, 16'd2, 16'd3);

        for (int v = 0; v < vq.size(); v++) begin
            a_in = vq[v].i;
            cyc();
            a_in = '0;
            chk($sformatf("vec%0d", v), 64'(a_out), 64'(vq[v].o));
        end

        // Randomized run on u_b against the round-level model.
        m_active = 0; m_gone = 0; m_pending = 0; m_left = 0; m_elapsed = 0;
        exp_b = '0;
        for (int n = 0; n < 4000; n++) begin
            in_t ri;
            ri.st = ($urandom_range(0, 39) == 0);
            ri.ab = ($urandom_range(0, 99) == 0);
            ri.h1 = ($urandom_range(0, 24) == 0);
            ri.h2 = ($urandom_range(0, 24) == 0);
            ri.tk = ($urandom_range(0, 1) == 1);
            model_step(ri);
            b_in = ri;
            cyc();
            chk($sformatf("rand%0d", n), 64'(b_out), 64'(exp_b));
        end
        b_in = '0;

        // Default parameters: every drawn delay matches the LFSR and stays in range.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] lf;
            logic [15:0] dexp;
            lf = ref_lfsr;
            dexp = sat_add16(16'd1000, lf & 16'h0FFF);
            c_in = S;
            cyc();
            chk("delay_exact", 64'(c_d), 64'(dexp));
            chk("delay_range", 64'((c_d >= 16'd1000) && (c_d <= 16'd5095)), 64'd1);
            chk("lfsr_nonzero", 64'(u_c.w_lfsr != 16'h0000), 64'd1);
            c_in = A;
            cyc();
        end
        c_in = '0;

        // Reset asserted mid-GO clears everything, including held results.
        a_in = S; cyc();
        a_in = T; cyc(); cyc(); cyc();
        a_in = '0;
        chk("go_before_reset", 64'(a_go), 64'd1);
        reset_n = 1'b0;
        cyc();
        chk("reset_mid_go", 64'(a_out), 64'(out_t'('0)));
        reset_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
